adc_capture_ram: RTL and testbench

Parametrised single-clock sample-capture memory for the ADC path. It is the next generation of the on-chip dual-port buffer. One side accepts an Avalon-ST sample stream into a circular RAM and runs a pre/post-trigger capture state machine. The other side is an Avalon-MM slave pair, one for memory readout/test-pattern load and one for control/status, and it raises an interrupt when a capture completes.

---
 rtl/adc_capture_ram.sv | 146 ++++++++++++++
 tb/tb_adc_capture_ram.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ram.sv
// adc_capture_ram: circular ADC sample capture RAM with pre/post-trigger FSM,
// Avalon-MM readout/test-pattern port and CSR slave with capture-done interrupt.
module adc_capture_ram #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 13,
    parameter int DEPTH        = 5000,
    parameter int READ_LATENCY = 1,
    parameter int POST_DEFAULT = 2500
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic                trig,
    input  logic [ADDR_W-1:0]   mem_address,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W-1:0]   mem_readdata,
    output logic                mem_readdatavalid,
    input  logic [1:0]          csr_address,
    input  logic                csr_read,
    input  logic                csr_write,
    input  logic [31:0]         csr_writedata,
    output logic [31:0]         csr_readdata,
    output logic                irq
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ARMED = 3'd2, POST = 3'd3, DONE = 3'd4} state_t;
    state_t state, state_next;
    logic [ADDR_W-1:0] wr_ptr, ptr_next, pre_cnt, post_left, post_len, trig_addr, start_addr, len_wr, len_sat;
    logic irq_en, done, active, accept, ctrl_wr, arm, abort, pre_hit, last, in_range, mem_ok;
    logic rd_v, rd_ok, unused_bits;
    logic [DATA_W-1:0] rd_q;
    logic [31:0] csr_mux;
    logic [DATA_W-1:0] mem [DEPTH];

    assign active    = state == PRE || state == ARMED || state == POST;
    assign st_ready  = active;
    assign accept    = st_valid && active;
    assign ctrl_wr   = csr_write && csr_address == 2'd0;
    assign abort     = ctrl_wr && csr_writedata[1];
    assign arm       = ctrl_wr && csr_writedata[0] && !csr_writedata[1];
    assign ptr_next  = wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
    assign pre_hit   = 32'(pre_cnt) + 32'd1 == 32'(DEPTH) - 32'(post_len);
    // post_len counts the trigger sample, so a length of 1 finishes on the trigger itself
    assign last      = (state == ARMED ? post_len : post_left) == ADDR_W'(1);
    assign len_wr    = csr_writedata[ADDR_W-1:0];
    assign len_sat   = (len_wr == '0 || 32'(len_wr) >= 32'(DEPTH)) ? LAST : len_wr;
    assign in_range  = 32'(mem_address) < 32'(DEPTH);
    assign mem_ok    = mem_write && !active && in_range;
    assign unused_bits = ^csr_writedata[31:ADDR_W];
    assign csr_mux   = csr_address == 2'd0 ? {29'b0, irq_en, 2'b0} :
                       csr_address == 2'd1 ? {27'b0, done, 1'b0, state} :
                       csr_address == 2'd2 ? 32'(post_len) :
                       {16'(trig_addr), 16'(start_addr)};

    always_comb begin
        state_next = state;
        if (abort && active) state_next = IDLE;
        else if (arm && !active) state_next = PRE;
        else if (accept && state == PRE && pre_hit) state_next = ARMED;
        else if (accept && state == ARMED && trig) state_next = last ? DONE : POST;
        else if (accept && state == POST && last) state_next = DONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            pre_cnt      <= '0;
            post_left    <= '0;
            post_len     <= ADDR_W'(POST_DEFAULT);
            trig_addr    <= '0;
            start_addr   <= '0;
            irq_en       <= 1'b0;
            done         <= 1'b0;
            irq          <= 1'b0;
            csr_readdata <= '0;
        end else begin
            state        <= state_next;
            irq          <= done && irq_en;
            csr_readdata <= csr_read ? csr_mux : '0;
            if (ctrl_wr) irq_en <= csr_writedata[2];
            if (csr_write && csr_address == 2'd2 && !active) post_len <= len_sat;
            if (csr_write && csr_address == 2'd1) done <= 1'b0;
            if (accept) begin
                wr_ptr    <= ptr_next;
                pre_cnt   <= pre_cnt + 1'b1;
                post_left <= (state == ARMED ? post_len : post_left) - 1'b1;
            end
            if (accept && state == ARMED && trig) trig_addr <= wr_ptr;
            if (state_next == DONE && state != DONE) begin
                start_addr <= ptr_next;
                done       <= 1'b1;
            end
            if (arm && !active) begin
                wr_ptr  <= '0;
                pre_cnt <= '0;
                done    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[IW-1:0]] <= st_data;
        else if (mem_ok)
            for (int b = 0; b < DATA_W / 8; b++)
                if (mem_byteenable[b]) mem[mem_address[IW-1:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
        rd_q <= mem[mem_address[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_v  <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            rd_v  <= mem_read;
            rd_ok <= mem_read && in_range;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic [DATA_W-1:0] q2;
            logic v2;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    q2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    q2 <= rd_ok ? rd_q : '0;
                    v2 <= rd_v;
                end
            end
            assign mem_readdata      = q2;
            assign mem_readdatavalid = v2;
        end else begin : g_rl1
            assign mem_readdata      = rd_ok ? rd_q : '0;
            assign mem_readdatavalid = rd_v;
        end
    endgenerate
endmodule

// File: tb/tb_adc_capture_ram.sv
// tb_adc_capture_ram: directed bench; u0 uses default parameters (latency 1),
// u1 is a 16-word, latency-2 build sharing the same input stimulus.
module tb_adc_capture_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;
    logic [15:0] st_data = '0;
    logic st_valid = 1'b0, trig = 1'b0;
    logic [12:0] mem_address = '0;
    logic mem_read = 1'b0, mem_write = 1'b0;
    logic [1:0] mem_byteenable = '0;
    logic [15:0] mem_writedata = '0;
    logic [1:0] csr_address = '0;
    logic csr_read = 1'b0, csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic st_ready0, st_ready1, mem_readdatavalid0, mem_readdatavalid1, irq0, irq1;
    logic [15:0] mem_readdata0, mem_readdata1;
    logic [31:0] csr_readdata0, csr_readdata1;
    int tests = 0, fails = 0;

    adc_capture_ram u0 (
        .clk(clk), .reset_n(reset_n), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready0),
        .trig(trig), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata0),
        .mem_readdatavalid(mem_readdatavalid0), .csr_address(csr_address), .csr_read(csr_read),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata0), .irq(irq0)
    );

    adc_capture_ram #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(2), .POST_DEFAULT(5)) u1 (
        .clk(clk), .reset_n(reset_n), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready1),
        .trig(trig), .mem_address(mem_address[4:0]), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata1),
        .mem_readdatavalid(mem_readdatavalid1), .csr_address(csr_address), .csr_read(csr_read),
        .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata1), .irq(irq1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        step();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
        csr_address = a; csr_read = 1'b1;
        step();
        csr_read = 1'b0;
        r0 = csr_readdata0; r1 = csr_readdata1;
    endtask

    task automatic mem_wr(input logic [12:0] a, input logic [15:0] d, input logic [1:0] be);
        mem_address = a; mem_writedata = d; mem_byteenable = be; mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    // u0 data is taken one cycle after the request, u1 data two cycles after
    task automatic rd2(input logic [12:0] a, output logic [15:0] d0, output logic [15:0] d1);
        mem_address = a; mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        d0 = mem_readdata0;
        step();
        d1 = mem_readdata1;
    endtask

    task automatic send(input logic [15:0] d, input logic t);
        st_data = d; st_valid = 1'b1; trig = t;
        step();
        st_valid = 1'b0; trig = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r0, r1;
        reset_n = 1'b0;
        step(); step();
        tests++;
        if ({st_ready0, st_ready1, irq0, irq1, mem_readdatavalid0, mem_readdatavalid1, csr_readdata0, csr_readdata1, mem_readdata0, mem_readdata1} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        reset_n = 1'b1;
        csr_rd(2'd2, r0, r1);
        tests++; if (r0 !== 32'd2500) begin fails++; $display("FAIL post_len_rst0: got %0d want 2500", r0); end
        tests++; if (r1 !== 32'd5) begin fails++; $display("FAIL post_len_rst1: got %0d want 5", r1); end
        csr_rd(2'd1, r0, r1);
        tests++; if ({r0, r1} !== 64'd0) begin fails++; $display("FAIL status_rst: got %h/%h want 0/0", r0, r1); end
        mem_address = 13'd5; mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        tests++; if (mem_readdatavalid0 !== 1'b1) begin fails++; $display("FAIL rdvalid_lat1: got %b want 1", mem_readdatavalid0); end
        step();
        tests++; if (mem_readdatavalid0 !== 1'b0) begin fails++; $display("FAIL rdvalid_pulse: got %b want 0", mem_readdatavalid0); end
    endtask

    task automatic test_byte_enable();
        logic [15:0] d0, d1;
        mem_wr(13'd7, 16'hABCD, 2'b01);
        mem_wr(13'd7, 16'h1200, 2'b10);
        rd2(13'd7, d0, d1);
        tests++; if (d0 !== 16'h12CD) begin fails++; $display("FAIL byte_lanes0: got %h want 12cd", d0); end
        tests++; if (d1 !== 16'h12CD) begin fails++; $display("FAIL byte_lanes1: got %h want 12cd", d1); end
        mem_wr(13'd100, 16'h5555, 2'b11);
        mem_wr(13'd5000, 16'hFFFF, 2'b11);
        rd2(13'd5000, d0, d1);
        tests++; if (d0 !== 16'h0000) begin fails++; $display("FAIL oob_read0: got %h want 0", d0); end
        rd2(13'd20, d0, d1);
        tests++; if (d1 !== 16'h0000) begin fails++; $display("FAIL oob_read1: got %h want 0", d1); end
        mem_wr(13'd9, 16'h1111, 2'b11);
        mem_address = 13'd9; mem_writedata = 16'h2222; mem_byteenable = 2'b11;
        mem_write = 1'b1; mem_read = 1'b1;
        step();
        mem_write = 1'b0; mem_read = 1'b0;
        tests++; if (mem_readdata0 !== 16'h1111) begin fails++; $display("FAIL rdw_old: got %h want 1111", mem_readdata0); end
        rd2(13'd9, d0, d1);
        tests++; if (d0 !== 16'h2222) begin fails++; $display("FAIL rdw_new: got %h want 2222", d0); end
    endtask

    task automatic test_post_len();
        logic [31:0] r0, r1;
        csr_wr(2'd2, 32'd0);
        csr_rd(2'd2, r0, r1);
        tests++; if ({r0, r1} !== {32'd4999, 32'd15}) begin fails++; $display("FAIL post_len_zero: got %0d/%0d want 4999/15", r0, r1); end
        csr_wr(2'd2, 32'd20);
        csr_rd(2'd2, r0, r1);
        tests++; if ({r0, r1} !== {32'd20, 32'd15}) begin fails++; $display("FAIL post_len_big: got %0d/%0d want 20/15", r0, r1); end
        csr_wr(2'd2, 32'd4);
        csr_rd(2'd2, r0, r1);
        tests++; if ({r0, r1} !== {32'd4, 32'd4}) begin fails++; $display("FAIL post_len_4: got %0d/%0d want 4/4", r0, r1); end
    endtask

    task automatic test_capture();
        logic [31:0] r0, r1;
        logic [15:0] d0, d1;
        csr_wr(2'd0, 32'd1);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd1) begin fails++; $display("FAIL arm_pre: got %h want 1", r1); end
        mem_wr(13'd100, 16'hDEAD, 2'b11);
        for (int i = 0; i < 11; i++) send(16'(i), i == 3);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd1) begin fails++; $display("FAIL pre_trig_ignored: got %h want 1", r1); end
        send(16'd11, 1'b0);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd2) begin fails++; $display("FAIL armed_after_12: got %h want 2", r1); end
        for (int i = 12; i < 20; i++) send(16'(i), 1'b0);
        send(16'd20, 1'b1);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd3) begin fails++; $display("FAIL post_state: got %h want 3", r1); end
        send(16'd21, 1'b0);
        send(16'd22, 1'b0);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd3) begin fails++; $display("FAIL still_post: got %h want 3", r1); end
        send(16'd23, 1'b0);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'h14) begin fails++; $display("FAIL done_status: got %h want 14", r1); end
        csr_rd(2'd3, r0, r1);
        tests++; if (r1 !== 32'h0004_0008) begin fails++; $display("FAIL capture_addr: got %h want 00040008", r1); end
        tests++; if (st_ready1 !== 1'b0) begin fails++; $display("FAIL ready_done: got %b want 0", st_ready1); end
        send(16'd99, 1'b0);
        for (int a = 0; a < 16; a++) begin
            rd2(13'(a), d0, d1);
            tests++;
            if (d1 !== 16'(a >= 8 ? a : a + 16)) begin fails++; $display("FAIL ram_%0d: got %0d want %0d", a, d1, a >= 8 ? a : a + 16); end
        end
        rd2(13'd100, d0, d1);
        tests++; if (d0 !== 16'h5555) begin fails++; $display("FAIL write_blocked_active: got %h want 5555", d0); end
    endtask

    task automatic test_irq();
        logic [31:0] r0, r1;
        csr_wr(2'd0, 32'd5);
        csr_rd(2'd0, r0, r1);
        tests++; if (r1 !== 32'd4) begin fails++; $display("FAIL irq_en_read: got %h want 4", r1); end
        for (int i = 0; i < 12; i++) send(16'h40 + 16'(i), 1'b0);
        send(16'h4C, 1'b1);
        for (int i = 13; i < 16; i++) send(16'h40 + 16'(i), 1'b0);
        tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_not_yet: got %b want 0", irq1); end
        step();
        tests++; if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b want 1", irq1); end
        step(); step();
        tests++; if ({irq1, irq0, st_ready1} !== 3'b100) begin fails++; $display("FAIL irq_held: got %b want 100", {irq1, irq0, st_ready1}); end
        csr_rd(2'd3, r0, r1);
        tests++; if (r1 !== 32'h000C_0000) begin fails++; $display("FAIL wrap_addr: got %h want 000c0000", r1); end
        csr_wr(2'd1, 32'd0);
        step();
        tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq1); end
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd4) begin fails++; $display("FAIL done_cleared: got %h want 4", r1); end
    endtask

    task automatic test_abort();
        logic [31:0] r0, r1;
        csr_wr(2'd0, 32'd1);
        for (int i = 0; i < 12; i++) send(16'(i), 1'b0);
        send(16'd12, 1'b1);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd3) begin fails++; $display("FAIL abort_pre_post: got %h want 3", r1); end
        csr_wr(2'd0, 32'd2);
        csr_rd(2'd1, r0, r1);
        tests++; if ({r0, r1} !== 64'd0) begin fails++; $display("FAIL abort_idle: got %h/%h want 0/0", r0, r1); end
        tests++; if ({st_ready0, st_ready1} !== 2'b00) begin fails++; $display("FAIL abort_ready: got %b want 00", {st_ready0, st_ready1}); end
        csr_wr(2'd0, 32'd3);
        csr_rd(2'd1, r0, r1);
        tests++; if ({r0, r1} !== 64'd0) begin fails++; $display("FAIL arm_abort: got %h/%h want 0/0", r0, r1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r0, r1;
        logic [15:0] d0, d1;
        csr_wr(2'd0, 32'd5);
        for (int i = 0; i < 12; i++) send(16'h100 + 16'(i), 1'b0);
        send(16'h10C, 1'b1);
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd3) begin fails++; $display("FAIL mid_post: got %h want 3", r1); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        tests++; if ({irq1, st_ready1} !== 2'b00) begin fails++; $display("FAIL mid_reset_out: got %b want 00", {irq1, st_ready1}); end
        csr_rd(2'd1, r0, r1);
        tests++; if (r1 !== 32'd0) begin fails++; $display("FAIL mid_reset_idle: got %h want 0", r1); end
        csr_rd(2'd2, r0, r1);
        tests++; if (r1 !== 32'd5) begin fails++; $display("FAIL mid_reset_len: got %0d want 5", r1); end
        rd2(13'd3, d0, d1);
        tests++; if (d1 !== 16'h0103) begin fails++; $display("FAIL ram_kept: got %h want 0103", d1); end
    endtask

    task automatic test_back_to_back();
        logic ev;
        for (int i = 0; i < 6; i++) begin
            mem_read = i < 4;
            mem_address = 13'(i);
            step();
            ev = i >= 1 && i <= 4;
            tests++;
            if (mem_readdatavalid1 !== ev) begin fails++; $display("FAIL b2b_valid1_%0d: got %b want %b", i, mem_readdatavalid1, ev); end
            tests++;
            if (mem_readdatavalid0 !== (i < 4)) begin fails++; $display("FAIL b2b_valid0_%0d: got %b want %b", i, mem_readdatavalid0, i < 4); end
            if (ev) begin
                tests++;
                if (mem_readdata1 !== 16'h100 + 16'(i - 1)) begin fails++; $display("FAIL b2b_data_%0d: got %h want %h", i, mem_readdata1, 16'h100 + 16'(i - 1)); end
            end
        end
        mem_read = 1'b0;
    endtask

    initial begin
        step();
        test_reset();
        test_byte_enable();
        test_post_len();
        test_capture();
        test_irq();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
